// File: rtl/gshare_direction_predictor.sv
`default_nettype none
// ============================================================================
// Module   : gshare_direction_predictor
// Brief    : gshare conditional-branch direction predictor with a speculative
//            global history, per-ID metadata for repair and a self-init sweep.
// Revision : 1.0  initial release
// ============================================================================
module gshare_direction_predictor #(
    parameter int ENTRIES = 512,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 9,
    parameter int ID_W    = 3
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_done,
    input  logic            lookup_valid,
    input  logic [31:0]     lookup_pc,
    input  logic [ID_W-1:0] lookup_id,
    input  logic            br_hint,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            upd_valid,
    input  logic [ID_W-1:0] upd_id,
    input  logic            upd_taken
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int IDS   = 1 << ID_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CTR_W-1:0] ctr_t;
    typedef logic [GHR_W-1:0] ghr_t;

    localparam ctr_t CTR_MAX  = {CTR_W{1'b1}};
    localparam ctr_t CTR_WNT  = ctr_t'((1 << (CTR_W - 1)) - 1);
    localparam idx_t IDX_LAST = idx_t'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t state_q;
    idx_t   sweep_q;
    logic   init_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + idx_t'(1);
                    if (sweep_q == IDX_LAST) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_READY;
            endcase
        end
    end

    ctr_t mem_q      [ENTRIES];
    idx_t meta_idx_q [IDS];
    ctr_t meta_ctr_q [IDS];
    logic meta_pt_q  [IDS];
    ghr_t meta_ghr_q [IDS];

    ghr_t ghr_q;
    logic pred_valid_q;
    ctr_t ctr_q;
    idx_t rsp_idx_q;
    logic [ID_W-1:0] rsp_id_q;

    // Update path reads metadata combinationally, so it sees the pre-write entry
    idx_t upd_idx;
    ctr_t upd_ctr_old;
    ctr_t upd_ctr_new;
    ghr_t upd_ghr;
    logic upd_en;
    logic mispredict;

    assign upd_en      = upd_valid & init_done_q;
    assign upd_idx     = meta_idx_q[upd_id];
    assign upd_ctr_old = meta_ctr_q[upd_id];
    assign upd_ghr     = meta_ghr_q[upd_id];
    assign mispredict  = upd_en & (upd_taken != meta_pt_q[upd_id]);

    always_comb begin
        upd_ctr_new = upd_ctr_old;
        if (upd_taken) begin
            if (upd_ctr_old != CTR_MAX) upd_ctr_new = upd_ctr_old + ctr_t'(1);
        end else begin
            if (upd_ctr_old != '0) upd_ctr_new = upd_ctr_old - ctr_t'(1);
        end
    end

    logic wr_en;
    idx_t wr_idx;
    ctr_t wr_data;

    always_comb begin
        wr_en   = 1'b1;
        wr_idx  = sweep_q;
        wr_data = CTR_WNT;
        if (init_done_q) begin
            wr_en   = upd_valid;
            wr_idx  = upd_idx;
            wr_data = upd_ctr_new;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    logic lk_en;
    idx_t lk_idx;

    assign lk_en  = lookup_valid & init_done_q;
    assign lk_idx = lookup_pc[IDX_W+1:2] ^ idx_t'(ghr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            ctr_q        <= '0;
            rsp_idx_q    <= '0;
            rsp_id_q     <= '0;
        end else begin
            pred_valid_q <= lk_en;
            if (lk_en) begin
                ctr_q     <= (wr_en && (wr_idx == lk_idx)) ? wr_data : mem_q[lk_idx];
                rsp_idx_q <= lk_idx;
                rsp_id_q  <= lookup_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pred_valid_q) begin
            meta_idx_q[rsp_id_q] <= rsp_idx_q;
            meta_ctr_q[rsp_id_q] <= ctr_q;
            meta_pt_q[rsp_id_q]  <= ctr_q[CTR_W-1];
            meta_ghr_q[rsp_id_q] <= ghr_q;
        end
    end

    ghr_t ghr_repair;
    ghr_t ghr_shift;

    generate
        if (GHR_W == 1) begin : g_ghr_single
            assign ghr_repair = upd_taken;
            assign ghr_shift  = ctr_q[CTR_W-1];
        end else begin : g_ghr_multi
            assign ghr_repair = {upd_ghr[GHR_W-2:0], upd_taken};
            assign ghr_shift  = {ghr_q[GHR_W-2:0], ctr_q[CTR_W-1]};
        end
    endgenerate

    // A hinted branch seen alongside a repair is on the wrong path: repair wins
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (mispredict) begin
            ghr_q <= ghr_repair;
        end else if (pred_valid_q && br_hint) begin
            ghr_q <= ghr_shift;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0], upd_ghr[GHR_W-1]};

    assign init_done  = init_done_q;
    assign pred_valid = pred_valid_q;
    assign pred_taken = ctr_q[CTR_W-1];

endmodule
`default_nettype wire

// File: tb/tb_gshare_direction_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_direction_predictor
// Brief    : directed + random bench for the gshare predictor against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gshare_direction_predictor;

    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int GHR_W   = 4;
    localparam int ID_W    = 3;
    localparam int NID     = 1 << ID_W;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int WNT     = (1 << (CTR_W - 1)) - 1;
    localparam int GMASK   = (1 << GHR_W) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            init_done;
    logic            lookup_valid = 1'b0;
    logic [31:0]     lookup_pc = '0;
    logic [ID_W-1:0] lookup_id = '0;
    logic            br_hint = 1'b0;
    logic            pred_valid;
    logic            pred_taken;
    logic            upd_valid = 1'b0;
    logic [ID_W-1:0] upd_id = '0;
    logic            upd_taken = 1'b0;

    always #5 clk = ~clk;

    gshare_direction_predictor #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .GHR_W   (GHR_W),
        .ID_W    (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_done    (init_done),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .lookup_id    (lookup_id),
        .br_hint      (br_hint),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .upd_valid    (upd_valid),
        .upd_id       (upd_id),
        .upd_taken    (upd_taken)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain counters table, history value and metadata records
    int tbl [ENTRIES];
    int ghr_m  = 0;
    bit rdy_m  = 0;
    int icnt   = 0;
    bit rv_m   = 0;
    int ridx_m = 0;
    int rctr_m = 0;
    int rid_m  = 0;
    int m_idx [NID];
    int m_ctr [NID];
    int m_pt  [NID];
    int m_snap[NID];
    bit m_val [NID];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit lv, input logic [31:0] pc, input int lid,
                        input bit hint, input bit uv, input int uid, input bit ut);
        int nc;
        int lkidx;
        int rep;
        bit mis;
        rst          = r;
        lookup_valid = lv;
        lookup_pc    = pc;
        lookup_id    = ID_W'(lid);
        br_hint      = hint;
        upd_valid    = uv;
        upd_id       = ID_W'(uid);
        upd_taken    = ut;
        @(posedge clk);
        mis = 0;
        rep = 0;
        if (r) begin
            rdy_m = 0; icnt = 0; ghr_m = 0; rv_m = 0; rctr_m = 0;
            for (int k = 0; k < NID; k++) m_val[k] = 0;
        end else if (!rdy_m) begin
            tbl[icnt] = WNT;
            icnt++;
            if (icnt == ENTRIES) rdy_m = 1;
            rv_m = 0;
        end else begin
            if (uv) begin
                nc = ut ? ((m_ctr[uid] < CMAX) ? m_ctr[uid] + 1 : CMAX)
                        : ((m_ctr[uid] > 0) ? m_ctr[uid] - 1 : 0);
                tbl[m_idx[uid]] = nc;
                mis = (int'(ut) != m_pt[uid]);
                rep = ((m_snap[uid] << 1) | int'(ut)) & GMASK;
            end
            lkidx = (int'(pc >> 2) & (ENTRIES - 1)) ^ ghr_m;
            if (rv_m) begin
                m_idx[rid_m]  = ridx_m;
                m_ctr[rid_m]  = rctr_m;
                m_pt[rid_m]   = rctr_m >> (CTR_W - 1);
                m_snap[rid_m] = ghr_m;
                m_val[rid_m]  = 1;
            end
            if (mis) ghr_m = rep;
            else if (rv_m && hint) ghr_m = ((ghr_m << 1) | (rctr_m >> (CTR_W - 1))) & GMASK;
            if (lv) begin
                rv_m = 1; ridx_m = lkidx; rctr_m = tbl[lkidx]; rid_m = lid;
            end else begin
                rv_m = 0;
            end
        end
        #1;
        chk("init_done", init_done, rdy_m);
        chk("pred_valid", pred_valid, rv_m);
        if (rv_m || r) chk("pred_taken", pred_taken, rctr_m >> (CTR_W - 1));
        chk("ghr", dut.ghr_q, ghr_m);
    endtask

    task automatic idle(input bit hint);
        step(0, 0, 32'h0, 0, hint, 0, 0, 0);
    endtask

    task automatic reset_and_sweep();
        step(1, 1, 32'h100, 0, 0, 1, 0, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_pred_valid", pred_valid, 0);
        for (int i = 0; i < ENTRIES; i++) begin
            step(0, 1, 32'h100, 0, 1, 0, 0, 0);
            if (i < ENTRIES - 1) chk("init_low", init_done, 0);
        end
        chk("init_high", init_done, 1);
    endtask

    initial begin
        int uid;
        bit uv;
        step(1, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("rst_pred_taken", pred_taken, 0);
        reset_and_sweep();

        // First lookup after init sees a weakly not-taken counter
        step(0, 1, 32'h100, 0, 0, 0, 0, 0);
        chk("first_pred", pred_taken, 0);
        idle(0);
        // Taken update on index 0 forwarded to a same-cycle lookup of index 0
        step(0, 1, 32'h100, 1, 0, 1, 0, 1);
        chk("fwd_pred", pred_taken, 1);
        chk("repair_ghr", dut.ghr_q, 1);
        idle(1);
        chk("shift_ghr", dut.ghr_q, 3);
        // Repair of ID 1 collides with the hinted response of ID 2
        step(0, 1, 32'h104, 2, 0, 0, 0, 0);
        step(0, 0, 32'h0, 0, 1, 1, 1, 0);
        chk("collision_ghr", dut.ghr_q, 2);

        for (int i = 0; i < 8; i++) begin
            step(0, 1, 32'h100, 3, 0, 0, 0, 0);
            idle(0);
            step(0, 0, 32'h0, 0, 0, 1, 3, 1);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h100, 4, 0, 0, 0, 0);
            idle(0);
            step(0, 0, 32'h0, 0, 0, 1, 4, 0);
        end

        reset_and_sweep();

        for (int n = 0; n < 3000; n++) begin
            uid = int'($urandom_range(NID - 1));
            for (int k = 0; k < NID && !m_val[uid]; k++) uid = (uid + 1) % NID;
            uv = m_val[uid] && ($urandom_range(1) == 1);
            step(0, $urandom_range(3) != 0, $urandom, int'($urandom_range(NID - 1)),
                 1'($urandom_range(1)), uv, uid, 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_direction_predictor.md
# gshare_direction_predictor

Parametrised gshare conditional-branch direction predictor for the fetch stage. It is the successor to the 2-bit bimodal scheme: a global-history-indexed table of saturating counters, with configurable counter width, table depth, history length and ID space. It keeps a speculative global history register (GHR) with per-ID checkpoints and repairs it on misprediction. After reset it initialises its own table with a sweep FSM, so no RAM reset is needed.

## Interface
Parameters:
- ENTRIES, 512, counter table depth; power of two, >= 16.
- CTR_W, 2, saturating counter width; 1..4.
- GHR_W, 9, global history length; 1..log2(ENTRIES).
- ID_W, 3, instruction ID width; metadata table depth = 2^ID_W.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  table sweep complete; lookups and updates are ignored while 0.
- lookup_valid  in  1  new fetch request this cycle.
- lookup_pc  in  32  fetch PC.
- lookup_id  in  ID_W  ID assigned to this fetch.
- br_hint  in  1  response-cycle qualifier: the fetched instruction is a conditional branch (from BTB).
- pred_valid  out  1  prediction available; one cycle after an accepted lookup.
- pred_taken  out  1  predicted direction; equals MSB of the indexed counter.
- upd_valid  in  1  resolved conditional branch from the branch unit.
- upd_id  in  ID_W  ID of the resolved branch.
- upd_taken  in  1  actual direction.

## Operation
- Index = lookup_pc[IDX_W+1:2] XOR zero-extended GHR, where IDX_W = log2(ENTRIES). The GHR value used is the one current in the lookup cycle.
- Counter table: simple dual-port RAM, one write port and one read port, 1-cycle read latency.
- Metadata LUTRAM is indexed by ID. It is written in the response cycle when pred_valid=1 and holds {index, counter, pred_taken, ghr_snapshot}. ghr_snapshot is the GHR before this branch's shift.
- Speculative GHR: in the response cycle, if pred_valid & br_hint, GHR <= {GHR[GHR_W-2:0], pred_taken}.
- Update, when upd_valid & init_done:
  - Read metadata[upd_id].
  - Write the counter at the stored index: increment saturating at 2^CTR_W-1 if taken; decrement saturating at 0 if not taken.
  - If upd_taken != stored pred_taken (mispredict): GHR <= {ghr_snapshot[GHR_W-2:0], upd_taken}.
- Counter forwarding: if an update writes the index being read in the same cycle, the response uses the newly written value.
- FSM states:
  - INIT: a counter walks 0..ENTRIES-1, writing 2^(CTR_W-1)-1 (weakly not-taken) to one entry per cycle. After the entry ENTRIES-1 write, go to READY.
  - READY: normal operation.
  - rst in any state returns to INIT with the sweep counter at 0.
- Simultaneous mispredict repair and br_hint shift in the same cycle: repair wins and the shift is discarded, because the hinted branch is on the wrong path.
- Update and lookup on the same ID in the same cycle: the update reads the old metadata; the new metadata write takes effect at the end of the cycle.

## Timing
- Reset values: init_done=0, pred_valid=0, pred_taken=0, GHR=0, FSM=INIT, sweep counter=0.
- init_done rises exactly ENTRIES cycles after rst deasserts.
- Lookup latency: 1 cycle. lookup_valid at cycle N with init_done=1 gives pred_valid=1 at N+1. pred_valid is never asserted during INIT.
- A counter write at cycle M is visible to lookups issued at M (forwarded) and to all later lookups.
- GHR repair at M affects indexes of lookups at M+1 onward.
- Throughput: one lookup and one update per cycle, no stalls.

## Test plan
- Init sweep, ENTRIES=16, CTR_W=2: release rst -> init_done=0 for 16 cycles then 1; first lookup of any PC -> pred_taken=0 (counter 1).
- Saturation, GHR held at 0: branch at 0x100 updated taken 3 times -> next prediction taken; then 1 not-taken -> still taken (counter 2); 2 more not-taken -> not-taken.
- CTR_W=3: 4 taken updates from init (counter 3) -> counter 7 saturates after 4 more; pred_taken flips to 1 after the first update (counter 4).
- GHR repair: predict not-taken with br_hint, GHR 0x000 -> 0x000; resolve taken -> GHR=0x001. A lookup at the same PC one cycle later uses index pc[10:2]^0x001.
- Collision: same-cycle mispredict repair and br_hint shift -> GHR equals repaired value only.
- Forwarding: update writes index 5 while a lookup reads index 5 -> pred_taken reflects the written counter.
- Reset mid-operation: assert rst during READY -> init_done=0 next cycle and the full 16-cycle sweep repeats.
